// File: rtl/draw_scheduler.sv
// Draw-job scheduler: turns cursor/toggle/playhead requests into per-cell draw-engine commands.
// Optional power-up clear of the whole grid when DRAW_SCHED_CLEAR_EN is defined.
module draw_scheduler #(
  parameter int GRID_SIZE = 12
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic       cur_req,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic       tog_req,
  input  logic [3:0] tog_x,
  input  logic [3:0] tog_y,
  input  logic       play_req,
  input  logic [3:0] play_col,
  output logic       cur_ack,
  output logic       tog_ack,
  output logic       play_ack,
  output logic [3:0] rd_x,
  output logic [3:0] rd_y,
  input  logic       rd_state,
  output logic       draw_start,
  output logic [3:0] draw_x,
  output logic [3:0] draw_y,
  output logic [2:0] draw_style,
  input  logic       draw_busy,
  output logic       sched_busy
);

  localparam logic [3:0] GSZ  = 4'(GRID_SIZE);
  localparam logic [3:0] LAST = 4'(GRID_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {WALK_CELL, WALK_COL, WALK_RASTER} walk_t;

  state_t     state;
  walk_t      walk;
  logic [3:0] cell_x, cell_y;
  logic       nxt_vld, nxt_col;
  logic [3:0] nxt_x, nxt_y;
  logic [3:0] cur_cx, cur_cy;
  logic [3:0] play_q;
  logic       walk_done;
  logic       cur_ok, tog_ok, play_ok;
`ifdef DRAW_SCHED_CLEAR_EN
  logic       clr_pend;
`endif

  assign rd_x = cell_x;
  assign rd_y = cell_y;

  assign cur_ok  = (cur_x < GSZ) && (cur_y < GSZ);
  assign tog_ok  = (tog_x < GSZ) && (tog_y < GSZ);
  assign play_ok = (play_col < GSZ);

  // Last cell of the current walk segment
  always_comb begin
    walk_done = 1'b1;
    case (walk)
      WALK_CELL:   walk_done = 1'b1;
      WALK_COL:    walk_done = (cell_y == LAST);
      WALK_RASTER: walk_done = (cell_x == LAST) && (cell_y == LAST);
      default:     walk_done = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      walk       <= WALK_CELL;
      cell_x     <= 4'd0;
      cell_y     <= 4'd0;
      nxt_vld    <= 1'b0;
      nxt_col    <= 1'b0;
      nxt_x      <= 4'd0;
      nxt_y      <= 4'd0;
      cur_cx     <= 4'd0;
      cur_cy     <= 4'd0;
      play_q     <= GSZ;
      cur_ack    <= 1'b0;
      tog_ack    <= 1'b0;
      play_ack   <= 1'b0;
      draw_start <= 1'b0;
      draw_x     <= 4'd0;
      draw_y     <= 4'd0;
      draw_style <= 3'd0;
      sched_busy <= 1'b0;
`ifdef DRAW_SCHED_CLEAR_EN
      clr_pend   <= 1'b1;
`endif
    end else begin
      cur_ack    <= 1'b0;
      tog_ack    <= 1'b0;
      play_ack   <= 1'b0;
      draw_start <= 1'b0;
      case (state)
        IDLE: begin
`ifdef DRAW_SCHED_CLEAR_EN
          if (clr_pend) begin
            clr_pend   <= 1'b0;
            walk       <= WALK_RASTER;
            cell_x     <= 4'd0;
            cell_y     <= 4'd0;
            nxt_vld    <= 1'b0;
            state      <= ISSUE;
            sched_busy <= 1'b1;
          end else
`endif
          if (cur_req) begin
            cur_ack <= 1'b1;
            if (cur_ok) begin
              // Old cursor cell first, restyled against the new cursor
              cur_cx     <= cur_x;
              cur_cy     <= cur_y;
              cell_x     <= cur_cx;
              cell_y     <= cur_cy;
              walk       <= WALK_CELL;
              nxt_vld    <= (cur_x != cur_cx) || (cur_y != cur_cy);
              nxt_col    <= 1'b0;
              nxt_x      <= cur_x;
              nxt_y      <= cur_y;
              state      <= ISSUE;
              sched_busy <= 1'b1;
            end
          end else if (tog_req) begin
            tog_ack <= 1'b1;
            if (tog_ok) begin
              cell_x     <= tog_x;
              cell_y     <= tog_y;
              walk       <= WALK_CELL;
              nxt_vld    <= 1'b0;
              state      <= ISSUE;
              sched_busy <= 1'b1;
            end
          end else if (play_req) begin
            play_ack <= 1'b1;
            if (play_ok) begin
              play_q     <= play_col;
              walk       <= WALK_COL;
              cell_y     <= 4'd0;
              nxt_col    <= 1'b1;
              nxt_x      <= play_col;
              nxt_y      <= 4'd0;
              state      <= ISSUE;
              sched_busy <= 1'b1;
              if ((play_q < GSZ) && (play_q != play_col)) begin
                cell_x  <= play_q;
                nxt_vld <= 1'b1;
              end else begin
                cell_x  <= play_col;
                nxt_vld <= 1'b0;
              end
            end
          end
        end

        ISSUE: begin
          if (!draw_busy) begin
            draw_start <= 1'b1;
            draw_x     <= cell_x;
            draw_y     <= cell_y;
            draw_style <= {(cell_x == cur_cx) && (cell_y == cur_cy),
                           (cell_x == play_q), rd_state};
            state      <= WAIT;
          end
        end

        WAIT: begin
          // Engine busy is not yet valid while draw_start is still high
          if (!draw_start && !draw_busy) begin
            if (!walk_done) begin
              state <= ISSUE;
              if (walk == WALK_RASTER && cell_x == LAST) begin
                cell_x <= 4'd0;
                cell_y <= cell_y + 4'd1;
              end else if (walk == WALK_RASTER) begin
                cell_x <= cell_x + 4'd1;
              end else begin
                cell_y <= cell_y + 4'd1;
              end
            end else if (nxt_vld) begin
              state   <= ISSUE;
              nxt_vld <= 1'b0;
              cell_x  <= nxt_x;
              cell_y  <= nxt_col ? 4'd0 : nxt_y;
              walk    <= nxt_col ? WALK_COL : WALK_CELL;
            end else begin
              state      <= IDLE;
              sched_busy <= 1'b0;
            end
          end
        end

        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: a cell-list model fills an expected-draw queue on each
// acknowledged request; a monitor with a built-in draw-engine model pops and compares every draw.
module tb_draw_scheduler;

  localparam int G = 12;

  logic       CLOCK_50 = 1'b0;
  logic       nReset = 1'b0;
  logic       cur_req = 1'b0, tog_req = 1'b0, play_req = 1'b0;
  logic [3:0] cur_x = 4'd0, cur_y = 4'd0, tog_x = 4'd0, tog_y = 4'd0, play_col = 4'd0;
  logic       cur_ack, tog_ack, play_ack;
  logic [3:0] rd_x, rd_y;
  logic       rd_state;
  logic       draw_start;
  logic [3:0] draw_x, draw_y;
  logic [2:0] draw_style;
  logic       draw_busy = 1'b0;
  logic       sched_busy;

  logic grid [16][16];
  assign rd_state = grid[rd_y][rd_x];

  draw_scheduler #(.GRID_SIZE(G)) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset),
    .cur_req(cur_req), .cur_x(cur_x), .cur_y(cur_y),
    .tog_req(tog_req), .tog_x(tog_x), .tog_y(tog_y),
    .play_req(play_req), .play_col(play_col),
    .cur_ack(cur_ack), .tog_ack(tog_ack), .play_ack(play_ack),
    .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state),
    .draw_start(draw_start), .draw_x(draw_x), .draw_y(draw_y), .draw_style(draw_style),
    .draw_busy(draw_busy), .sched_busy(sched_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] style;
  } draw_t;

  draw_t exp_q[$];
  int errors = 0, checks = 0;
  int draw_cnt = 0;
  int busy_len = 4, busy_cnt = 0;
  int m_cx, m_cy, m_play;
  int req_x[3], req_y[3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] style_of(input int x, input int y);
    return {(x == m_cx) && (y == m_cy), x == m_play, grid[y][x]};
  endfunction

  task automatic push_cell(input int x, input int y);
    draw_t d;
    d.x = 4'(x);
    d.y = 4'(y);
    d.style = style_of(x, y);
    exp_q.push_back(d);
  endtask

  // Reference: list of cells each accepted job must draw, in order
  task automatic model_accept(input int k);
    int x, y, old;
    x = req_x[k];
    y = req_y[k];
    if (k == 0) begin
      if (x < G && y < G) begin
        int ox, oy;
        ox = m_cx; oy = m_cy;
        m_cx = x; m_cy = y;
        push_cell(ox, oy);
        if (ox != x || oy != y) push_cell(x, y);
      end
    end else if (k == 1) begin
      if (x < G && y < G) push_cell(x, y);
    end else begin
      if (x < G) begin
        old = m_play;
        m_play = x;
        if (old < G && old != x)
          for (int r = 0; r < G; r++) push_cell(old, r);
        for (int r = 0; r < G; r++) push_cell(x, r);
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cx = 0; m_cy = 0; m_play = G;
    cur_req = 1'b0; tog_req = 1'b0; play_req = 1'b0;
    draw_busy = 1'b0; busy_cnt = 0;
`ifdef DRAW_SCHED_CLEAR_EN
    for (int r = 0; r < G; r++)
      for (int c = 0; c < G; c++) push_cell(c, r);
`endif
  endtask

  task automatic raise(input int k, input int x, input int y);
    req_x[k] = x;
    req_y[k] = y;
    case (k)
      0: begin cur_x = 4'(x); cur_y = 4'(y); cur_req = 1'b1; end
      1: begin tog_x = 4'(x); tog_y = 4'(y); tog_req = 1'b1; end
      default: begin play_col = 4'(x); play_req = 1'b1; end
    endcase
  endtask

  function automatic int outs_word();
    return int'({cur_ack, tog_ack, play_ack, draw_start, sched_busy,
                 draw_x, draw_y, draw_style, rd_x, rd_y});
  endfunction

  // Monitor + draw-engine model, sampling 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (nReset) begin
        int n_acks, k, ek;
        n_acks = int'(cur_ack) + int'(tog_ack) + int'(play_ack);
        if (n_acks > 0) begin
          k  = cur_ack ? 0 : (tog_ack ? 1 : 2);
          ek = cur_req ? 0 : (tog_req ? 1 : (play_req ? 2 : 3));
          check("acks_per_cycle", n_acks, 1);
          check("ack_priority", k, ek);
          check("ack_with_draws_pending", exp_q.size(), 0);
          model_accept(k);
          case (k)
            0: cur_req = 1'b0;
            1: tog_req = 1'b0;
            default: play_req = 1'b0;
          endcase
        end
        if (draw_start) begin
          draw_t got, e;
          draw_cnt++;
          check("start_while_busy", int'(draw_busy), 0);
          check("start_with_ack", n_acks, 0);
          got = {draw_x, draw_y, draw_style};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_draw: got x=%0d y=%0d style=%b expected no draw",
                     draw_x, draw_y, draw_style);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (got != e) begin
              errors++;
              $display("FAIL draw_cell: got x=%0d y=%0d style=%b expected x=%0d y=%0d style=%b",
                       got.x, got.y, got.style, e.x, e.y, e.style);
            end
          end
          busy_cnt = busy_len;
          draw_busy = 1'b1;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) draw_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((cur_req || tog_req || play_req || exp_q.size() != 0 || sched_busy || draw_busy)
           && n < 5000) begin
      @(posedge CLOCK_50);
      #3;
      n++;
    end
    check(name, int'(n < 5000), 1);
    repeat (4) @(posedge CLOCK_50);
    #3;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    int d0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) grid[r][c] = 1'($urandom_range(0, 1));
    grid[0][0] = 1'b0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #2;
    check("reset_outputs", outs_word(), 0);
    nReset = 1'b1;

    // Cursor move to (3,2), 4-cycle engine
    busy_len = 4;
    step();
    d0 = draw_cnt;
    raise(0, 3, 2);
    wait_idle("cur_basic_done");
`ifdef DRAW_SCHED_CLEAR_EN
    check("cur_basic_draws", draw_cnt - d0, G * G + 2);
`else
    check("cur_basic_draws", draw_cnt - d0, 2);
`endif
    check("sched_busy_idle", int'(sched_busy), 0);

    // Three requests in the same cycle
    step();
    raise(0, 5, 5); raise(1, 1, 7); raise(2, 4, 0);
    wait_idle("three_req_done");

    // Playhead 11 then wrap to 0
    step(); raise(2, 11, 0);
    wait_idle("play11_done");
    step(); d0 = draw_cnt; raise(2, 0, 0);
    wait_idle("play_wrap_done");
    check("play_wrap_draws", draw_cnt - d0, 2 * G);

    // Out-of-range requests: acked, nothing drawn
    step(); d0 = draw_cnt; raise(1, 12, 3);
    wait_idle("tog_oob_done");
    step(); raise(0, 4, 15);
    wait_idle("cur_oob_done");
    step(); raise(2, 13, 0);
    wait_idle("play_oob_done");
    check("oob_draws", draw_cnt - d0, 0);

    // Cursor to its current cell: single draw
    step(); d0 = draw_cnt; raise(0, 5, 5);
    wait_idle("cur_same_done");
    check("cur_same_draws", draw_cnt - d0, 1);

    // Long engine busy
    busy_len = 50;
    step(); d0 = draw_cnt; raise(1, 2, 9); raise(0, 6, 1);
    wait_idle("long_busy_done");
    check("long_busy_draws", draw_cnt - d0, 3);

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      busy_len = int'($urandom_range(1, 6));
      step();
      for (int k = 0; k < 3; k++) begin
        logic pend;
        pend = (k == 0) ? cur_req : ((k == 1) ? tog_req : play_req);
        if (!pend && $urandom_range(0, 2) == 0)
          raise(k, int'($urandom_range(0, 13)), int'($urandom_range(0, 13)));
      end
      repeat ($urandom_range(0, 30)) step();
    end
    wait_idle("random_done");

    // Reset in the middle of a playhead job
    busy_len = 3;
    step(); raise(2, 7, 0);
    repeat (25) step();
    check("midjob_busy", int'(sched_busy), 1);
    @(posedge CLOCK_50);
    #3;
    nReset = 1'b0;
    model_reset();
    #1;
    check("midjob_reset_outputs", outs_word(), 0);
    repeat (3) @(posedge CLOCK_50);
    #2;
    nReset = 1'b1;
    step(); d0 = draw_cnt; raise(0, 8, 4);
    wait_idle("post_reset_done");
`ifdef DRAW_SCHED_CLEAR_EN
    check("post_reset_draws", draw_cnt - d0, G * G + 2);
`else
    check("post_reset_draws", draw_cnt - d0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
